interrupt_sequencer: RTL and testbench

Pipeline-level controller that turns an external interrupt request into a fixed, cycle-exact sequence. It holds fetch, injects three context-save instructions into the decode slot, redirects fetch to the ISR vector, then waits for RTI and restores flags and PC. It sits beside the IF/ID buffer and drives the decode-stage instruction mux, the fetch hold and PC-load inputs, and the saved-flags register.

---
 rtl/interrupt_sequencer.sv | 139 +++++++++++++
 tb/tb_interrupt_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: holds fetch, injects three context pushes, vectors, then restores on RTI.
// Optional IRQ_SYNC_EN adds a 2-flop irq synchronizer ahead of edge detection (+2 cycles acceptance latency).
module interrupt_sequencer #(
  parameter int                     PC_WIDTH         = 32,
  parameter int                     INSTR_WIDTH      = 16,
  parameter logic [PC_WIDTH-1:0]    VECTOR_ADDR      = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] PUSH_HI_INSTR    = 16'h4001,
  parameter logic [INSTR_WIDTH-1:0] PUSH_LO_INSTR    = 16'h4002,
  parameter logic [INSTR_WIDTH-1:0] PUSH_FLAGS_INSTR = 16'h4003
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   irq_i,
  input  logic                   flush_i,
  input  logic [PC_WIDTH-1:0]    next_pc_i,
  input  logic                   rti_i,
  output logic                   fetch_hold_o,
  output logic                   inject_valid_o,
  output logic [INSTR_WIDTH-1:0] inject_instr_o,
  output logic                   pc_load_o,
  output logic [PC_WIDTH-1:0]    pc_load_addr_o,
  output logic                   flags_save_o,
  output logic                   flags_restore_o,
  output logic                   in_service_o,
  output logic [PC_WIDTH-1:0]    saved_pc_o,
  output logic                   irq_dropped_o
);

  typedef enum logic [2:0] {
    IDLE, INJ_HI, INJ_LO, INJ_FLAGS, VECTOR, SERVICE, RESTORE
  } state_e;

  state_e              state_q, state_d;
  logic                irq_s;
  logic                irq_prev_q;
  logic                pending_q, pending_d;
  logic                dropped_q, dropped_d;
  logic [PC_WIDTH-1:0] saved_pc_q, saved_pc_d;
  logic                irq_edge;
  logic                accept;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], irq_i};
    end
  end

  assign irq_s = sync_q[1];
`else
  assign irq_s = irq_i;
`endif

  assign irq_edge = irq_s & ~irq_prev_q;
  assign accept   = (state_q == IDLE) & pending_q & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      dropped_q  <= 1'b0;
      saved_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  // A new edge wins over the clear on acceptance, so it is never counted as dropped.
  always_comb begin
    pending_d  = irq_edge ? 1'b1 : (accept ? 1'b0 : pending_q);
    dropped_d  = dropped_q | (irq_edge & pending_q & ~accept);
    saved_pc_d = accept ? next_pc_i : saved_pc_q;
  end

  always_comb begin
    state_d         = state_q;
    fetch_hold_o    = 1'b0;
    inject_valid_o  = 1'b0;
    inject_instr_o  = '0;
    pc_load_o       = 1'b0;
    pc_load_addr_o  = '0;
    flags_save_o    = 1'b0;
    flags_restore_o = 1'b0;
    in_service_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = INJ_HI;
      end
      INJ_HI: begin
        fetch_hold_o   = 1'b1;
        inject_valid_o = 1'b1;
        inject_instr_o = PUSH_HI_INSTR;
        state_d        = INJ_LO;
      end
      INJ_LO: begin
        fetch_hold_o   = 1'b1;
        inject_valid_o = 1'b1;
        inject_instr_o = PUSH_LO_INSTR;
        state_d        = INJ_FLAGS;
      end
      INJ_FLAGS: begin
        fetch_hold_o   = 1'b1;
        inject_valid_o = 1'b1;
        inject_instr_o = PUSH_FLAGS_INSTR;
        flags_save_o   = 1'b1;
        state_d        = VECTOR;
      end
      VECTOR: begin
        pc_load_o      = 1'b1;
        pc_load_addr_o = VECTOR_ADDR;
        state_d        = SERVICE;
      end
      SERVICE: begin
        in_service_o = 1'b1;
        if (rti_i) state_d = RESTORE;
      end
      RESTORE: begin
        flags_restore_o = 1'b1;
        pc_load_o       = 1'b1;
        pc_load_addr_o  = saved_pc_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign saved_pc_o    = saved_pc_q;
  assign irq_dropped_o = dropped_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios with literal expectations, then random traffic vs a cycle-offset model.
module tb_interrupt_sequencer;
`ifdef IRQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, irq, flush, rti;
  logic [31:0] next_pc;
  logic        fetch_hold, inject_valid, pc_load, flags_save, flags_restore, in_service, irq_dropped;
  logic [15:0] inject_instr;
  logic [31:0] pc_load_addr, saved_pc;

  interrupt_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .flush_i(flush), .next_pc_i(next_pc), .rti_i(rti),
    .fetch_hold_o(fetch_hold), .inject_valid_o(inject_valid), .inject_instr_o(inject_instr),
    .pc_load_o(pc_load), .pc_load_addr_o(pc_load_addr), .flags_save_o(flags_save),
    .flags_restore_o(flags_restore), .in_service_o(in_service), .saved_pc_o(saved_pc),
    .irq_dropped_o(irq_dropped)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] push_word(input int k);
    case (k)
      0:       return 16'h4001;
      1:       return 16'h4002;
      default: return 16'h4003;
    endcase
  endfunction

  // Model: a sequence is described by the number of cycles since acceptance.
  bit          m_pend, m_dropped, m_active, m_restore;
  int          m_off;
  logic [31:0] m_saved;
  logic [2:0]  m_hist;

  always @(posedge clk or negedge rst_n) begin : model
    bit s_now, s_prev, e, acc, take;
    if (!rst_n) begin
      m_pend = 0; m_dropped = 0; m_active = 0; m_restore = 0;
      m_off = 0; m_saved = '0; m_hist = '0;
    end else begin
      s_now  = (SD == 2) ? m_hist[1] : irq;
      s_prev = (SD == 2) ? m_hist[2] : m_hist[0];
      e      = s_now & ~s_prev;
      acc    = !m_active && !m_restore && m_pend && !flush;
      take   = m_active && m_off >= 4 && rti;
      m_restore = 0;
      if (acc) begin
        m_active = 1; m_off = 0; m_saved = next_pc;
      end else if (take) begin
        m_active = 0; m_restore = 1;
      end else if (m_active && m_off < 4) begin
        m_off++;
      end
      m_dropped = m_dropped | (e & m_pend & !acc);
      m_pend    = e ? 1'b1 : (acc ? 1'b0 : m_pend);
      m_hist    = {m_hist[1:0], irq};
    end
  end

  always @(posedge clk) begin : compare
    bit inj;
    #1;
    if (rst_n) begin
      inj = m_active && m_off < 3;
      chk("m_fetch_hold", fetch_hold, inj);
      chk("m_inject_valid", inject_valid, inj);
      chk("m_inject_instr", inject_instr, inj ? push_word(m_off) : 16'h0);
      chk("m_flags_save", flags_save, m_active && m_off == 2);
      chk("m_pc_load", pc_load, (m_active && m_off == 3) || m_restore);
      chk("m_pc_load_addr", pc_load_addr, m_restore ? m_saved : 32'h0);
      chk("m_flags_restore", flags_restore, m_restore);
      chk("m_in_service", in_service, m_active && m_off >= 4);
      chk("m_saved_pc", saved_pc, m_saved);
      chk("m_irq_dropped", irq_dropped, m_dropped);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; irq = 0; flush = 0; rti = 0; next_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_hold", fetch_hold, 0);
    chk("rst_instr", inject_instr, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_saved", saved_pc, 0);
    chk("rst_dropped", irq_dropped, 0);
    rst_n = 1;

    // Basic entry sequence
    @(negedge clk); irq = 1; next_pc = 32'h120;
    tick(); repeat (SD) tick();
    chk("e0_hold", fetch_hold, 0);
    tick();
    chk("e1_instr", inject_instr, 16'h4001);
    chk("e1_hold", fetch_hold, 1);
    chk("e1_saved", saved_pc, 32'h120);
    next_pc = 32'h999;
    tick();
    chk("e2_instr", inject_instr, 16'h4002);
    chk("e2_fsave", flags_save, 0);
    irq = 0;
    tick();
    chk("e3_instr", inject_instr, 16'h4003);
    chk("e3_fsave", flags_save, 1);
    tick();
    chk("e4_pcl", pc_load, 1);
    chk("e4_addr", pc_load_addr, 0);
    chk("e4_hold", fetch_hold, 0);
    chk("e4_saved", saved_pc, 32'h120);
    tick();
    chk("e5_isv", in_service, 1);
    @(negedge clk); rti = 1;
    tick();
    rti = 0;
    chk("r_frest", flags_restore, 1);
    chk("r_pcl", pc_load, 1);
    chk("r_addr", pc_load_addr, 32'h120);
    tick();
    chk("r1_isv", in_service, 0);
    chk("r1_pcl", pc_load, 0);

    // Acceptance deferred by flush
    @(negedge clk); irq = 1; flush = 1; next_pc = 32'h200;
    repeat (SD) @(negedge clk);
    @(negedge clk); chk("fl_hold", fetch_hold, 0);
    @(negedge clk); chk("fl_hold2", fetch_hold, 0); flush = 0; next_pc = 32'h204;
    tick();
    chk("fl_instr", inject_instr, 16'h4001);
    chk("fl_saved", saved_pc, 32'h204);
    irq = 0;
    repeat (5) tick();
    chk("fl_isv", in_service, 1);
    @(negedge clk); rti = 1;
    @(negedge clk); rti = 0;
    repeat (2) @(negedge clk);

    // Two further edges during service: one pending, one dropped
    next_pc = 32'h120;
    @(negedge clk); irq = 1;
    repeat (6 + SD) @(negedge clk);
    chk("n_isv", in_service, 1);
    irq = 0;
    @(negedge clk); irq = 1;
    @(negedge clk); irq = 0;
    @(negedge clk); irq = 1;
    @(negedge clk); irq = 0;
    repeat (SD + 1) @(negedge clk);
    chk("n_dropped", irq_dropped, 1);
    chk("n_isv2", in_service, 1);
    rti = 1;
    tick();
    rti = 0;
    chk("n_r_addr", pc_load_addr, 32'h120);
    tick();
    chk("n_r1_hold", fetch_hold, 0);
    chk("n_r1_isv", in_service, 0);
    tick();
    chk("n_r2_instr", inject_instr, 16'h4001);
    repeat (4) tick();
    chk("n_isv3", in_service, 1);
    @(negedge clk); rti = 1;
    @(negedge clk); rti = 0;
    repeat (4) @(negedge clk);
    chk("n_once_hold", fetch_hold, 0);
    chk("n_once_isv", in_service, 0);

    // Reset during INJ_LO
    @(negedge clk); irq = 1; next_pc = 32'h300;
    repeat (3 + SD) tick();
    chk("rs_instr", inject_instr, 16'h4002);
    #2; rst_n = 0; irq = 0;
    #1;
    chk("rs_hold", fetch_hold, 0);
    chk("rs_instr0", inject_instr, 0);
    chk("rs_saved", saved_pc, 0);
    chk("rs_dropped", irq_dropped, 0);
    @(negedge clk); rst_n = 1;
    repeat (6) tick();
    chk("rs_quiet_hold", fetch_hold, 0);
    chk("rs_quiet_isv", in_service, 0);

    // rti in IDLE
    @(negedge clk); rti = 1;
    tick();
    chk("ri_pcl", pc_load, 0);
    chk("ri_frest", flags_restore, 0);
    @(negedge clk); rti = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) irq = ~irq;
      flush   = ($urandom_range(3) == 0);
      rti     = ($urandom_range(7) == 0);
      next_pc = $urandom;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
